// File: rtl/pio_pipelined_adder.sv
// pio_pipelined_adder
//   Consumes the HPS PIO operand exports adder_a/adder_b and produces the
//   value fed back into the adder_sum PIO input. Any change on either operand
//   is captured and added in a carry-chained pipeline of DATA_W/SLICE_W slice
//   stages. The last result is held stable with a done pulse, a settled flag
//   and a completion count.
//
//   Optional feature macro: ADDER_OVF_EN
//     defined   : carry_out / ovf report unsigned carry and signed overflow of
//                 the current adder_sum, registered together with it.
//     undefined : carry_out / ovf are tied low.
//
// Ports
//   clk        system clock (same clock as the PIO exports)
//   reset      synchronous, active-high
//   adder_a    operand A
//   adder_b    operand B
//   adder_sum  registered result, held between completions
//   sum_done   one-cycle pulse on each adder_sum update
//   settled    result matches the captured operands, nothing in flight
//   add_count  completed additions, wraps
//   carry_out  carry out of the MSB (ADDER_OVF_EN)
//   ovf        signed overflow (ADDER_OVF_EN)
//
// Timing: the capture edge loads a_q/b_q and sets stage-0 valid; slices are
// added on the next N edges and adder_sum updates one edge later, giving
// N+1 edges from capture to result.

module pio_pipelined_adder #(
    parameter int DATA_W  = 64,
    parameter int SLICE_W = 16,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] adder_a,
    input  logic [DATA_W-1:0] adder_b,
    output logic [DATA_W-1:0] adder_sum,
    output logic              sum_done,
    output logic              settled,
    output logic [CNT_W-1:0]  add_count,
    output logic              carry_out,
    output logic              ovf
);

    localparam int N = DATA_W / SLICE_W;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              cmp;
    logic              done_seen;

    // st_v[0] is the capture stage; st_v[k] (k>=1) means slice k-1 is added.
    logic [N:0]        st_v;
    logic [DATA_W-1:0] st_a [1:N];
    logic [DATA_W-1:0] st_b [1:N];
    logic [DATA_W-1:0] st_s [1:N];
    logic              st_c [1:N];

    // Inputs to each slice adder and the values it hands to the next stage.
    logic [DATA_W-1:0] src_a [0:N-1];
    logic [DATA_W-1:0] src_b [0:N-1];
    logic [DATA_W-1:0] src_s [0:N-1];
    logic              src_c [0:N-1];
    logic [DATA_W-1:0] nxt_s [0:N-1];
    logic              nxt_c [0:N-1];

    assign cmp = (adder_a != a_q) || (adder_b != b_q);

    for (genvar k = 0; k < N; k++) begin : g_slice
        logic [SLICE_W:0] part;

        if (k == 0) begin : g_first
            assign src_a[k] = a_q;
            assign src_b[k] = b_q;
            assign src_s[k] = '0;
            assign src_c[k] = 1'b0;
        end else begin : g_rest
            assign src_a[k] = st_a[k];
            assign src_b[k] = st_b[k];
            assign src_s[k] = st_s[k];
            assign src_c[k] = st_c[k];
        end

        assign part = {1'b0, src_a[k][k*SLICE_W +: SLICE_W]}
                    + {1'b0, src_b[k][k*SLICE_W +: SLICE_W]}
                    + {{SLICE_W{1'b0}}, src_c[k]};

        // Slices above k are still zero in src_s, so OR-ing places this one.
        assign nxt_s[k] = src_s[k] | (DATA_W'(part[SLICE_W-1:0]) << (k*SLICE_W));
        assign nxt_c[k] = part[SLICE_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            st_v      <= '0;
            adder_sum <= '0;
            sum_done  <= 1'b0;
            settled   <= 1'b0;
            add_count <= '0;
            done_seen <= 1'b0;
            for (int k = 1; k <= N; k++) begin
                st_a[k] <= '0;
                st_b[k] <= '0;
                st_s[k] <= '0;
                st_c[k] <= 1'b0;
            end
        end else begin
            if (cmp) begin
                a_q <= adder_a;
                b_q <= adder_b;
            end
            st_v <= {st_v[N-1:0], cmp};
            for (int k = 0; k < N; k++) begin
                st_a[k+1] <= src_a[k];
                st_b[k+1] <= src_b[k];
                st_s[k+1] <= nxt_s[k];
                st_c[k+1] <= nxt_c[k];
            end

            if (st_v[N]) begin
                adder_sum <= st_s[N];
                sum_done  <= 1'b1;
                add_count <= add_count + CNT_W'(1);
                done_seen <= 1'b1;
            end else begin
                sum_done  <= 1'b0;
            end

            // Looks at pre-edge state, so a completing add keeps settled low
            // for this edge and it rises on the following one.
            settled <= !cmp && (st_v == '0) && done_seen;
        end
    end

`ifdef ADDER_OVF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_out <= 1'b0;
            ovf       <= 1'b0;
        end else if (st_v[N]) begin
            carry_out <= st_c[N];
            ovf       <= (st_a[N][DATA_W-1] == st_b[N][DATA_W-1])
                      && (st_s[N][DATA_W-1] != st_a[N][DATA_W-1]);
        end
    end
`else
    assign carry_out = 1'b0;
    assign ovf       = 1'b0;
`endif

endmodule
